demux_1to3_stream: RTL and testbench

DEMUX_1TO3_STREAM -- requirements
Module: demux_1to3_stream

---
 rtl/demux_1to3_stream.sv | 142 ++++++++++++++
 tb/tb_demux_1to3_stream.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to3_stream.sv
// rtl/demux_1to3_stream.sv - 1-to-3 stream demultiplexer with 2-entry output FIFOs and per-output counters
module demux_1to3_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Per-output FIFO: slot0 is always the head, slot1 the second entry.
    occ_t             occ_q   [3];
    occ_t             occ_d   [3];
    logic [WIDTH-1:0] slot0_q [3];
    logic [WIDTH-1:0] slot0_d [3];
    logic [WIDTH-1:0] slot1_q [3];
    logic [WIDTH-1:0] slot1_d [3];
    logic [7:0]       cnt_q   [3];
    logic [7:0]       cnt_d   [3];

    logic [1:0] sel;
    logic [2:0] out_ready;
    logic [2:0] wr;
    logic [2:0] pop;

    assign out_ready = {out2_ready, out1_ready, out0_ready};

    // Decode route code and decide whether the addressed FIFO has room.
    always_comb begin
        sel = 2'd0;
        if (s0) begin
            sel = s1 ? 2'd2 : 2'd1;
        end
        in_ready = 1'b0;
        if (!rst) begin
            case (sel)
                2'd0:    in_ready = (occ_q[0] != OCC_FULL);
                2'd1:    in_ready = (occ_q[1] != OCC_FULL);
                2'd2:    in_ready = (occ_q[2] != OCC_FULL);
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Next-state for each FIFO: occupancy, storage shift and accept counter.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wr[i]      = in_valid && in_ready && (sel == 2'(i));
            pop[i]     = !rst && (occ_q[i] != OCC_EMPTY) && out_ready[i];
            occ_d[i]   = occ_q[i];
            slot0_d[i] = slot0_q[i];
            slot1_d[i] = slot1_q[i];
            cnt_d[i]   = cnt_q[i];
            case (occ_q[i])
                OCC_EMPTY: begin
                    if (wr[i]) begin
                        slot0_d[i] = in_data;
                        occ_d[i]   = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (wr[i] && pop[i]) begin
                        // Old head leaves, new word takes its place.
                        slot0_d[i] = in_data;
                    end else if (wr[i]) begin
                        slot1_d[i] = in_data;
                        occ_d[i]   = OCC_FULL;
                    end else if (pop[i]) begin
                        occ_d[i]   = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // Writes are never granted while full, even on a pop.
                    if (pop[i]) begin
                        slot0_d[i] = slot1_q[i];
                        occ_d[i]   = OCC_ONE;
                    end
                end
                default: begin
                    occ_d[i] = OCC_EMPTY;
                end
            endcase
            if (wr[i]) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                occ_q[i]   <= OCC_EMPTY;
                slot0_q[i] <= '0;
                slot1_q[i] <= '0;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                occ_q[i]   <= occ_d[i];
                slot0_q[i] <= slot0_d[i];
                slot1_q[i] <= slot1_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output views: head word while valid, zero otherwise.
    always_comb begin
        out0_valid = (occ_q[0] != OCC_EMPTY);
        out1_valid = (occ_q[1] != OCC_EMPTY);
        out2_valid = (occ_q[2] != OCC_EMPTY);
        out0_data  = out0_valid ? slot0_q[0] : '0;
        out1_data  = out1_valid ? slot0_q[1] : '0;
        out2_data  = out2_valid ? slot0_q[2] : '0;
        cnt0       = cnt_q[0];
        cnt1       = cnt_q[1];
        cnt2       = cnt_q[2];
    end

endmodule

// File: tb/tb_demux_1to3_stream.sv
// tb/tb_demux_1to3_stream.sv - scoreboard bench for demux_1to3_stream
module tb_demux_1to3_stream;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       s0;
    logic       s1;
    logic [7:0] out0_data, out1_data, out2_data;
    logic       out0_valid, out1_valid, out2_valid;
    logic       out0_ready, out1_ready, out2_ready;
    logic [7:0] cnt0, cnt1, cnt2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    demux_1to3_stream #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .s0(s0), .s1(s1),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge, so compare the head now.
    task automatic mon(input int n, input logic v, input logic r, input logic [7:0] d);
        logic [7:0] e;
        if (v && r) begin
            case (n)
                0: if (q0.size() == 0) check("out0_unexpected", 32'(d), 32'hx); else begin e = q0.pop_front(); check("out0_data", 32'(d), 32'(e)); end
                1: if (q1.size() == 0) check("out1_unexpected", 32'(d), 32'hx); else begin e = q1.pop_front(); check("out1_data", 32'(d), 32'(e)); end
                default: if (q2.size() == 0) check("out2_unexpected", 32'(d), 32'hx); else begin e = q2.pop_front(); check("out2_data", 32'(d), 32'(e)); end
            endcase
        end
    endtask

    always @(negedge clk) begin
        mon(0, out0_valid, out0_ready, out0_data);
        mon(1, out1_valid, out1_ready, out1_data);
        mon(2, out2_valid, out2_ready, out2_data);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [1:0] code);
        bit done;
        int tries;
        done = 0;
        tries = 0;
        in_data  = d;
        s0       = code[1];
        s1       = code[0];
        in_valid = 1'b1;
        while (!done && tries < 20) begin
            @(negedge clk);
            if (in_ready) begin
                if (code == 2'b11) q2.push_back(d);
                else if (code == 2'b10) q1.push_back(d);
                else q0.push_back(d);
                done = 1;
            end
            @(posedge clk);
            #1;
            tries++;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valids", 32'({out0_valid, out1_valid, out2_valid}), 32'd0);
        check("rst_cnts", {8'd0, cnt0, cnt1, cnt2}, 32'd0);
        step(2);
        rst = 1'b0;

        // Routing, all sinks ready.
        out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        send(8'hA1, 2'b00);
        check("lat_a1", {out0_valid, out0_data}, {1'b1, 8'hA1});
        send(8'hA2, 2'b01);
        check("lat_a2", {out0_valid, out0_data}, {1'b1, 8'hA2});
        send(8'hB1, 2'b10);
        check("lat_b1", {out1_valid, out1_data}, {1'b1, 8'hB1});
        send(8'hC1, 2'b11);
        check("lat_c1", {out2_valid, out2_data}, {1'b1, 8'hC1});
        step(2);
        check("route_cnts", {8'd0, cnt0, cnt1, cnt2}, {8'd0, 8'd2, 8'd1, 8'd1});

        // Backpressure on out1.
        out1_ready = 1'b0;
        send(8'h11, 2'b10);
        send(8'h22, 2'b10);
        in_data = 8'h33; s0 = 1'b1; s1 = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", {out1_valid, out1_data}, {1'b1, 8'h11});
            step(1);
        end
        out1_ready = 1'b1;
        @(negedge clk);
        check("bp_no_writethru", 32'(in_ready), 32'd0);
        step(1);
        in_valid = 1'b0;
        send(8'h33, 2'b10);
        step(2);
        check("bp_cnt1", 32'(cnt1), 32'd4);

        // Independence: out2 full and stalled, out0 still flows.
        out2_ready = 1'b0;
        send(8'h61, 2'b11);
        send(8'h62, 2'b11);
        s0 = 1'b1; s1 = 1'b1;
        #1;
        check("ind_full_ready", 32'(in_ready), 32'd0);
        step(1);
        send(8'h55, 2'b00);
        check("ind_out0", {out0_valid, out0_data}, {1'b1, 8'h55});
        check("ind_out2", {out2_valid, out2_data}, {1'b1, 8'h61});
        step(2);

        // Simultaneous write and pop on a ONE FIFO.
        out0_ready = 1'b0;
        send(8'h01, 2'b00);
        out0_ready = 1'b1;
        send(8'h02, 2'b00);
        check("sim_head", {out0_valid, out0_data}, {1'b1, 8'h02});
        out0_ready = 1'b0;
        s0 = 1'b0; s1 = 1'b0;
        #1;
        check("sim_one_room", 32'(in_ready), 32'd1);
        step(1);
        send(8'h03, 2'b00);
        s0 = 1'b0; s1 = 1'b0;
        #1;
        check("sim_now_full", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        step(4);

        // Fill every FIFO, then reset between edges.
        out0_ready = 1'b0; out1_ready = 1'b0;
        send(8'h71, 2'b00);
        send(8'h72, 2'b00);
        send(8'h81, 2'b10);
        send(8'h82, 2'b10);
        check("full_valids", 32'({out0_valid, out1_valid, out2_valid}), 32'h7);
        #1;
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        #1;
        check("arst_valids", 32'({out0_valid, out1_valid, out2_valid}), 32'd0);
        check("arst_data", {8'd0, out0_data, out1_data, out2_data}, 32'd0);
        check("arst_cnts", {8'd0, cnt0, cnt1, cnt2}, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hEE; s0 = 1'b0; s1 = 1'b0;
        step(2);
        check("rst_hold_ready", 32'(in_ready), 32'd0);
        check("rst_hold_state", {5'd0, out0_valid, out1_valid, out2_valid, cnt0, cnt1, cnt2}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        // Select changes with no valid must not disturb state.
        for (int k = 0; k < 4; k++) begin
            s0 = k[1]; s1 = k[0];
            step(1);
        end
        check("idle_sel", {5'd0, out0_valid, out1_valid, out2_valid, cnt0, cnt1, cnt2}, 32'd0);

        // Counter wrap on out2.
        for (int k = 0; k < 256; k++) begin
            send(8'(k), 2'b11);
        end
        check("wrap_256", 32'(cnt2), 32'd0);
        send(8'hF7, 2'b11);
        check("wrap_257", 32'(cnt2), 32'd1);
        step(4);
        check("sb_empty", q0.size() + q1.size() + q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
